ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the 32-bit ALU; registers ALU result, overflow flag and control bits into the memory stage.
- 2-entry skid buffer with valid/ready handshake on both sides; converts signed overflow into a precise trap and provides an EX->EX forwarding tap.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, PC)
REG_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_alu_out  in  DATA_W  ALU result
in_ovf  in  1  ALU overflow flag
in_ovf_chk  in  1  instruction traps on overflow (add/sub signed)
in_wdata  in  DATA_W  store data
in_rd  in  REG_W  destination register
in_reg_write  in  1  writes register file
in_mem_read  in  1  load
in_mem_write  in  1  store
in_pc  in  DATA_W  instruction PC
flush  in  1  kill all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_alu_out, out_wdata  out  DATA_W  head payload
out_rd  out  REG_W  head destination
out_reg_write, out_mem_read, out_mem_write  out  1  head controls (write controls already trap-masked)
exc_valid  out  1  overflow trap pending
exc_epc  out  DATA_W  PC of trapping instruction
exc_ack  in  1  trap handler acknowledge
fwd_valid  out  1  forwarding tap valid
fwd_rd  out  REG_W  forwarded register
fwd_data  out  DATA_W  forwarded value

Behaviour:
- Reset (rst_n=0, async): both entries invalid, out_valid=0, in_ready=1 after release, exc_valid=0, exc_epc=0, all payload outputs 0, fwd_valid=0.
- Accept = in_valid & in_ready; pop = out_valid & out_ready. Latency 1 cycle: accepted entry visible at outputs next cycle when buffer was empty.
- Occupancy states EMPTY/ONE/TWO. Accept only -> +1; pop only -> -1; accept & pop -> unchanged, head advances. TWO: in_ready=0.
- in_ready registered: = (state!=TWO) & !exc_valid & !(state==ONE & accept & !pop). No combinational path from out_ready to in_ready.
- Order strictly FIFO; skid entry moves to head on pop of head.
- Trap: accept with in_ovf & in_ovf_chk -> entry stored with reg_write=0, mem_write=0 (mem_read kept); next cycle exc_valid=1, exc_epc=in_pc. Entry still drains normally.
- While exc_valid=1: in_ready=0. exc_ack clears exc_valid next cycle. exc_ack with exc_valid=0 ignored.
- in_ovf with in_ovf_chk=0 (unsigned ops): no trap, payload unchanged.
- flush: next cycle state=EMPTY, out_valid=0; concurrent accept dropped, concurrent pop still counts downstream. flush does not clear exc_valid/exc_epc.
- Forwarding: fwd_valid = out_valid & out_reg_write & (out_rd!=0); fwd_rd=out_rd, fwd_data=out_alu_out; combinational from head registers.
- Output payload stable while out_valid=1 & out_ready=0.

Optional Feature:
- Macro EX_MEM_PERF_EN. Defined: adds outputs perf_stall_cnt[31:0] (cycles with in_valid & !in_ready) and perf_trap_cnt[31:0] (traps raised); saturate at 0xFFFFFFFF, reset to 0, unaffected by flush.
- Undefined: ports present, tied to 0, no counter logic.

Test Plan:
- Single accept in_alu_out=0x00000005, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_out=0x5, fwd_valid=1, fwd_rd=3; following cycle out_valid=0.
- out_ready=0, push 0x11,0x22 -> state TWO, in_ready=0; third push 0x33 held; out_ready=1 -> pops 0x11,0x22,0x33 in order, no loss or duplication.
- Accept with in_ovf=1, in_ovf_chk=1, in_pc=0x00400010, reg_write=1 -> out_reg_write=0, exc_valid=1, exc_epc=0x00400010, in_ready=0 until exc_ack; in_ovf=1, in_ovf_chk=0 -> no trap.
- TWO entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry never appears.
- rst_n low mid-stream with TWO entries and exc_valid=1 -> immediately out_valid=0, exc_valid=0, exc_epc=0.
- Head rd=0, reg_write=1 -> fwd_valid=0; with EX_MEM_PERF_EN, 3 blocked cycles -> perf_stall_cnt=3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a 2-entry skid buffer, precise overflow trap and forwarding tap.
// Optional EX_MEM_PERF_EN adds saturating stall/trap counters; otherwise the perf ports read 0.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_ovf,
  input  logic              in_ovf_chk,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              exc_valid,
  output logic [DATA_W-1:0] exc_epc,
  input  logic              exc_ack,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_trap_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  ent_t head, skid, in_ent;
  logic accept, pop, ovf_trap, trap, exc_nx;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign ovf_trap = in_ovf & in_ovf_chk;
  // a flushed accept never enters the buffer, so it cannot raise a trap either
  assign trap     = accept & ovf_trap & ~flush;
  assign exc_nx   = trap | (exc_valid & ~exc_ack);
  assign in_ent   = {in_alu_out, in_wdata, in_rd, in_reg_write & ~ovf_trap, in_mem_read, in_mem_write & ~ovf_trap};
  always_comb begin
    state_nx = flush ? EMPTY :
               (accept & ~pop) ? ((state == EMPTY) ? ONE : TWO) :
               (pop & ~accept) ? ((state == TWO) ? ONE : EMPTY) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      exc_valid <= 1'b0;
      exc_epc   <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != TWO) & ~exc_nx;
      exc_valid <= exc_nx;
      if (trap) exc_epc <= in_pc;
      if (!flush) begin
        if (accept & ((state == EMPTY) | ((state == ONE) & pop))) head <= in_ent;
        else if (pop & (state == TWO)) head <= skid;
        if (accept & (state == ONE) & ~pop) skid <= in_ent;
      end
    end
  end
  assign out_valid     = state != EMPTY;
  assign out_alu_out   = head.alu;
  assign out_wdata     = head.wdata;
  assign out_rd        = head.rd;
  assign out_reg_write = head.rw;
  assign out_mem_read  = head.mr;
  assign out_mem_write = head.mw;
  assign fwd_valid     = out_valid & head.rw & (head.rd != '0);
  assign fwd_rd        = head.rd;
  assign fwd_data      = head.alu;
`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_trap_cnt  <= '0;
    end else begin
      if (in_valid & ~in_ready & (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (trap & (perf_trap_cnt != '1)) perf_trap_cnt <= perf_trap_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_trap_cnt  = '0;
`endif
endmodule
